// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the dual-clock FIFO write and read controllers.
//   bin2gray / gray2bin : pointer code conversions. They work on a 32-bit
//                         container; callers zero-extend narrower pointers and
//                         cast the result back to their own pointer width.
//   ovf_state_t         : sticky overflow/underflow flag states.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int CODE_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    FLAGGED = 1'b1
  } ovf_state_t;

  // Gray encoding is width-independent as long as the unused upper bits are 0.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it. Zero upper
  // bits contribute nothing, so this also works for any narrower width.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
    logic [CODE_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < CODE_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
// Write-domain controller of the dual-clock FIFO. It accepts producer writes
// and drives the RAM write port. It publishes a registered Gray write pointer
// for the read-domain synchronizer. From the synchronized Gray read pointer it
// derives full, almost_full, fill level and a sticky overflow flag.
//
// Ports
//   clk_src         in   write-domain clock
//   rst_n           in   asynchronous active-low reset
//   wr_valid        in   producer has a word
//   wr_ready        out  !full
//   wr_en_mem       out  RAM write strobe (wr_valid && !full), zero latency
//   wr_addr         out  RAM write address, low bits of the binary pointer
//   wptr_gray       out  registered Gray write pointer (ADDR_WIDTH+1 bits)
//   rptr_gray_sync  in   Gray read pointer, already synchronized into clk_src
//   full            out  registered full flag
//   almost_full     out  registered, free slots <= AF_THRESH
//   fill_level      out  registered occupancy, 0..depth
//   overflow        out  sticky: write attempted while full
//   clr_overflow    in   clears overflow; a simultaneous new overflow wins
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk_src,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_en_mem,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int A     = ADDR_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t AF_LEVEL = ptr_t'(DEPTH - AF_THRESH);

  ptr_t       wptr_bin;
  ptr_t       wptr_next;
  ptr_t       wgray_next;
  ptr_t       rptr_bin;
  ptr_t       fill_level_next;
  logic       accept;
  logic       full_next;
  logic       almost_full_next;
  ovf_state_t ovf_state;
  ovf_state_t ovf_state_next;

  assign accept    = wr_valid && !full;
  assign wr_ready  = !full;
  assign wr_en_mem = accept;
  assign wr_addr   = wptr_bin[A-1:0];
  assign overflow  = (ovf_state == FLAGGED);

  assign wptr_next  = accept ? wptr_bin + 1'b1 : wptr_bin;
  assign wgray_next = ptr_t'(bin2gray(CODE_W'(wptr_next)));
  assign rptr_bin   = ptr_t'(gray2bin(CODE_W'(rptr_gray_sync)));

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code, that means the top two bits are inverted and the rest are equal.
  assign full_next        = (wgray_next == {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]});
  // Modulo-2**(A+1) difference. The extra lap bit keeps it within 0..depth.
  assign fill_level_next  = wptr_next - rptr_bin;
  assign almost_full_next = (fill_level_next >= AF_LEVEL);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge and no ordering races occur.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      fill_level  <= '0;
    end else begin
      wptr_bin    <= wptr_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      fill_level  <= fill_level_next;
    end
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      ovf_state <= IDLE;
    end else begin
      ovf_state <= ovf_state_next;
    end
  end

  // NOTE: next-state gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ovf_state_next = ovf_state;
    unique case (ovf_state)
      IDLE: begin
        if (wr_valid && full) ovf_state_next = FLAGGED;
      end
      FLAGGED: begin
        // A new overflow in the clearing cycle keeps the flag set.
        if (clr_overflow && !(wr_valid && full)) ovf_state_next = IDLE;
      end
      default: ovf_state_next = IDLE;
    endcase
  end

endmodule
